// File: rtl/drum_voice_mixer_if.sv
// Bundle of the mixer's trigger, ROM and audio-output signals.
//   tick      : one-cycle pulse at the audio sample rate
//   go        : go[v] pulse triggers or retriggers voice v
//   gain      : gain code of voice v in gain[v*GAIN_W +: GAIN_W]
//   rom_addr  : {voice index, sample count} read address to the shared ROM
//   rom_data  : registered ROM read data, valid one cycle after rom_addr
//   out       : mixed, saturated sample; held between updates
//   out_valid : one-cycle pulse when out updates
//   active    : active[v] high while voice v is playing
//   overrun   : sticky flag, a tick arrived while a frame was still in progress
// The mixer connects through the slave modport; the controller side
// (sequencer, ROM, audio sink) uses the master modport.
interface drum_voice_mixer_if #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int GAIN_W     = 2
);
    localparam int VW = $clog2(NUM_VOICES);

    logic                           tick;
    logic [NUM_VOICES-1:0]          go;
    logic [NUM_VOICES*GAIN_W-1:0]   gain;
    logic [VW+ADDR_W-1:0]           rom_addr;
    logic signed [DATA_W-1:0]       rom_data;
    logic signed [DATA_W-1:0]       out;
    logic                           out_valid;
    logic [NUM_VOICES-1:0]          active;
    logic                           overrun;

    modport master (
        output tick, go, gain, rom_data,
        input  rom_addr, out, out_valid, active, overrun
    );

    modport slave (
        input  tick, go, gain, rom_data,
        output rom_addr, out, out_valid, active, overrun
    );
endinterface

// File: rtl/drum_voice_mixer.sv
// Polyphonic one-shot drum playback engine.
// On each accepted sample tick the engine walks all voices in turn over one
// shared registered ROM port, scales each voice's sample by its gain code,
// sums the terms in a wide accumulator and presents the saturated mix.
// Ports:
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : drum_voice_mixer_if.slave (tick/go/gain in, ROM port, mixed output,
//            per-voice activity and the sticky overrun flag)
module drum_voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int GAIN_W     = 2
) (
    input  logic clk,
    input  logic resetn,
    drum_voice_mixer_if.slave bus
);
    localparam int VW       = $clog2(NUM_VOICES);
    localparam int ACC_W    = DATA_W + VW + 1;
    localparam int MAXSHIFT = 2**GAIN_W - 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LAST, S_DONE} state_t;

    // Arithmetic-shift scaling: full gain code is unity, each step down halves.
    function automatic logic signed [ACC_W-1:0] scale_term(
        input logic signed [DATA_W-1:0] s,
        input logic [GAIN_W-1:0]        g,
        input logic                     act
    );
        logic signed [ACC_W-1:0] ext;
        logic [GAIN_W-1:0]       sh;
        ext = ACC_W'(s);
        sh  = GAIN_W'(MAXSHIFT) - g;
        if (!act || g == '0) begin
            return '0;
        end
        return ext >>> sh;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        lo = ~hi;
        if (a > hi) begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end else if (a < lo) begin
            return {1'b1, {(DATA_W-1){1'b0}}};
        end
        return a[DATA_W-1:0];
    endfunction

    state_t                    state_q, state_d;
    logic [VW-1:0]             vi_q, vi_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [ADDR_W-1:0]         count_q [NUM_VOICES];
    logic [ADDR_W-1:0]         count_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]     active_q, active_d;
    logic [NUM_VOICES-1:0]     pend_q, pend_d;
    logic signed [DATA_W-1:0]  out_q, out_d;
    logic                      out_valid_q, out_valid_d;
    logic                      overrun_q, overrun_d;

    logic [VW-1:0]             sel;
    logic [GAIN_W-1:0]         gain_sel;
    logic                      act_sel;
    logic signed [ACC_W-1:0]   term;
    logic [NUM_VOICES-1:0]     trig;

    // The address always follows the voice pointer; only FETCH cycles matter.
    assign bus.rom_addr  = {vi_q, count_q[vi_q]};
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.active    = active_q;
    assign bus.overrun   = overrun_q;

    always_comb begin
        state_d     = state_q;
        vi_d        = vi_q;
        acc_d       = acc_q;
        count_d     = count_q;
        active_d    = active_q;
        pend_d      = pend_q | bus.go;
        out_d       = out_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q | (bus.tick && state_q != S_IDLE);
        trig        = pend_q | bus.go;

        // ROM data arriving now belongs to the voice addressed one cycle ago:
        // vi-1 while fetching, the last voice (vi unchanged) in LAST.
        sel = (state_q == S_LAST) ? vi_q : vi_q - VW'(1);
        gain_sel = '0;
        act_sel  = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (VW'(v) == sel) begin
                gain_sel = bus.gain[v*GAIN_W +: GAIN_W];
                act_sel  = active_q[v];
            end
        end
        term = scale_term(bus.rom_data, gain_sel, act_sel);

        case (state_q)
            S_IDLE: begin
                if (bus.tick) begin
                    active_d = active_q | trig;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (trig[v]) begin
                            count_d[v] = '0;
                        end
                    end
                    pend_d  = '0;
                    acc_d   = '0;
                    vi_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (vi_q != '0) begin
                    acc_d = acc_q + term;
                end
                if (vi_q == VW'(NUM_VOICES-1)) begin
                    state_d = S_LAST;
                end else begin
                    vi_d = vi_q + 1'b1;
                end
            end
            S_LAST: begin
                // Register the saturated mix here so out and out_valid land together in DONE.
                acc_d       = acc_q + term;
                out_d       = sat(acc_d);
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (active_q[v]) begin
                        if (count_q[v] == '1) begin
                            active_d[v] = 1'b0;
                            count_d[v]  = '0;
                        end else begin
                            count_d[v] = count_q[v] + 1'b1;
                        end
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            vi_q        <= '0;
            acc_q       <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                count_q[v] <= '0;
            end
            active_q    <= '0;
            pend_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vi_q        <= vi_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end
endmodule

// File: tb/tb_drum_voice_mixer.sv
// Self-checking bench for drum_voice_mixer (4 voices, 13-bit regions, 8-bit samples).
// A behavioural ROM answers reads one cycle late; a frame-level model tracks
// per-voice activity, position and pending triggers and predicts each mix.
module tb_drum_voice_mixer;
    localparam int N      = 4;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam int GAIN_W = 2;
    localparam int SPAN   = 2**ADDR_W;

    logic clk;
    logic resetn;

    drum_voice_mixer_if #(.NUM_VOICES(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAIN_W(GAIN_W)) bus ();

    drum_voice_mixer #(.NUM_VOICES(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAIN_W(GAIN_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    logic signed [7:0] mem [0:N*SPAN-1];

    always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int       g [N];
    bit [3:0] m_active;
    bit [3:0] m_pend;
    int       m_cnt [N];
    int       last_out;
    int       pulses;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_gains(input int g0, input int g1, input int g2, input int g3);
        g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
        for (int v = 0; v < N; v++) bus.gain[v*GAIN_W +: GAIN_W] = 2'(g[v]);
    endtask

    task automatic model_reset();
        m_active = '0;
        m_pend   = '0;
        for (int v = 0; v < N; v++) m_cnt[v] = 0;
    endtask

    // Mix of the current model positions: shifted samples summed, then clamped.
    function automatic int expect_mix();
        int acc;
        acc = 0;
        for (int v = 0; v < N; v++) begin
            if (m_active[v] && g[v] != 0)
                acc += int'(mem[v*SPAN + m_cnt[v]]) >>> (3 - g[v]);
        end
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        return acc;
    endfunction

    task automatic go_pulse(input logic [3:0] mask);
        bus.go = mask;
        m_pend |= mask;
        step();
        bus.go = '0;
    endtask

    // One frame: tick (with go mask) now, optional go pulse and duplicate tick mid-frame.
    task automatic frame(input logic [3:0] gomask, input logic [3:0] midgo, input int dup_at);
        logic [3:0] trig;
        int expv;
        int lat;
        trig = m_pend | gomask;
        for (int v = 0; v < N; v++) begin
            if (trig[v]) begin
                m_active[v] = 1'b1;
                m_cnt[v]    = 0;
            end
        end
        m_pend = '0;
        expv = expect_mix();
        bus.tick = 1'b1;
        bus.go   = gomask;
        step();
        bus.tick = 1'b0;
        bus.go   = '0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            if (lat == 2 && midgo != '0) begin
                bus.go = midgo;
                m_pend |= midgo;
            end else begin
                bus.go = '0;
            end
            bus.tick = (dup_at != 0 && lat == dup_at);
            step();
            lat++;
        end
        bus.tick = 1'b0;
        bus.go   = '0;
        chk("latency", lat, 6);
        chk("mix_out", bus.out, expv);
        chk("active_in_done", bus.active, m_active);
        last_out = bus.out;
        for (int v = 0; v < N; v++) begin
            if (m_active[v]) begin
                if (m_cnt[v] == SPAN-1) begin
                    m_active[v] = 1'b0;
                    m_cnt[v]    = 0;
                end else begin
                    m_cnt[v]++;
                end
            end
        end
        step();
        chk("valid_one_cycle", bus.out_valid, 0);
        chk("active_after", bus.active, m_active);
    endtask

    initial begin
        resetn   = 1'b0;
        bus.tick = 1'b0;
        bus.go   = '0;
        set_gains(3, 3, 3, 3);
        model_reset();
        for (int i = 0; i < N*SPAN; i++) mem[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", bus.out, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_active", bus.active, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_addr", bus.rom_addr, 0);
        resetn = 1'b1;
        step();

        // Idle ticks with nothing triggered produce silent frames.
        repeat (3) begin
            frame(4'b0000, 4'b0000, 0);
            chk("silent", last_out, 0);
        end

        // Single voice at unity gain steps through its samples.
        for (int i = 0; i < 12; i++) mem[i] = 8'(10*(i+1));
        go_pulse(4'b0001);
        frame(4'b0000, 4'b0000, 0);
        chk("v0_first", last_out, 10);
        frame(4'b0000, 4'b0000, 0);
        chk("v0_second", last_out, 20);

        // Two voices summed past both rails.
        mem[0] = 100; mem[SPAN] = 100; mem[1] = -100; mem[SPAN+1] = -100;
        frame(4'b0011, 4'b0000, 0);
        chk("clamp_hi", last_out, 127);
        frame(4'b0000, 4'b0000, 0);
        chk("clamp_lo", last_out, -128);

        // Gain code 1 is a quarter; code 0 mutes without stopping the voice.
        set_gains(0, 0, 1, 3);
        mem[2*SPAN] = 64;
        frame(4'b0100, 4'b0000, 0);
        chk("gain_quarter", last_out, 16);
        set_gains(0, 0, 0, 3);
        frame(4'b0000, 4'b0000, 0);
        chk("gain_mute", last_out, 0);
        chk("muted_active", bus.active[2], 1);

        // Randomized triggers, mid-frame go pulses and gains.
        repeat (40) begin
            set_gains($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) go_pulse(4'($urandom));
            frame(4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0), 0);
        end
        chk("no_overrun", bus.overrun, 0);

        // A tick two cycles into a frame is dropped and flagged.
        frame(4'b0000, 4'b0000, 2);
        pulses = 0;
        repeat (10) begin
            if (bus.out_valid === 1'b1) pulses++;
            step();
        end
        chk("dropped_tick_pulses", pulses, 0);
        chk("overrun_set", bus.overrun, 1);

        // Reset in the middle of a frame clears every output at once.
        set_gains(0, 0, 0, 3);
        mem[3*SPAN] = 55;
        frame(4'b1000, 4'b0000, 0);
        chk("pre_reset_mix", last_out, 55);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        step();
        resetn = 1'b0;
        #1;
        chk("midrst_out", bus.out, 0);
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_active", bus.active, 0);
        chk("midrst_overrun", bus.overrun, 0);
        chk("midrst_addr", bus.rom_addr, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
        step();
        frame(4'b0000, 4'b0000, 0);
        chk("post_reset_silent", last_out, 0);

        // Play voice 1 through its whole region; the final sample is mixed, then it stops.
        set_gains(0, 3, 0, 0);
        frame(4'b0010, 4'b0000, 0);
        repeat (SPAN-1) frame(4'b0000, 4'b0000, 0);
        chk("one_shot_end", bus.active[1], 0);
        frame(4'b0000, 4'b0000, 0);
        chk("after_end_silent", last_out, 0);

        // Retrigger at position 5 restarts from address 0.
        set_gains(3, 0, 0, 0);
        mem[0] = 77; mem[5] = -33;
        frame(4'b0001, 4'b0000, 0);
        repeat (4) frame(4'b0000, 4'b0000, 0);
        frame(4'b0001, 4'b0000, 0);
        chk("retrig_restart", last_out, 77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
